// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg : shared constants for the Life board sequencer  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package life_pkg;
  localparam int DEF_W         = 32;
  localparam int DEF_H         = 24;
  localparam int DEF_GEN_W     = 16;
  localparam int SETTLE_CYCLES = 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STABLE = 2'd2;
endpackage

`default_nettype wire

// File: rtl/tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider : free-running cycle counter with a one-cycle wrap pulse  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tick_divider #(
  parameter int TICK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int             CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end
endmodule

`default_nettype wire

// File: rtl/board_sequencer.sv
// ---------------------------------------------------------------------------
// board_sequencer : holds the Life board and commits one generation per tick
// or step. Optional still-life halt: BOARD_SEQ_STABLE_DETECT_EN  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module board_sequencer
  import life_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int H        = DEF_H,
  parameter int L        = W * H,
  parameter int TICK_DIV = 2,
  parameter int GEN_W    = DEF_GEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 step,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [$clog2(L)-1:0] wr_addr,
  input  logic                 wr_data,
  input  logic [L-1:0]         board_next,
  output logic [L-1:0]         board,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 gen_tick,
  output logic                 stable
);
  localparam int             AW          = $clog2(L);
  localparam int             SW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [AW:0]    L_LIM       = (AW + 1)'(L);
  localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE_CYCLES);

  logic [1:0]    state, state_nx;
  logic          pending;
  logic [SW-1:0] settle;
  logic          div_tick, div_clr, leave_run, wr_ok, commit, set_pending;

  assign leave_run   = (state == ST_RUN) && !run;
  assign div_clr     = clear || leave_run;
  assign wr_ok       = wr_en && ({1'b0, wr_addr} < L_LIM);
  assign set_pending = div_tick || ((state == ST_IDLE) && step);
  // Any edit this cycle wins over the commit; settle then delays it until
  // the downstream stage has seen the edited board.
  assign commit      = pending && (settle == '0) && !clear && !wr_en &&
                       !leave_run && (state != ST_STABLE);

  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == ST_RUN),
    .clr  (div_clr),
    .tick (div_tick)
  );

`ifdef BOARD_SEQ_STABLE_DETECT_EN
  logic same;
  assign same   = (board_next == board);
  assign stable = (state == ST_STABLE);
`else
  assign stable = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (run) state_nx = ST_RUN;
      ST_RUN: begin
        if (!run) state_nx = ST_IDLE;
`ifdef BOARD_SEQ_STABLE_DETECT_EN
        else if (commit && same) state_nx = ST_STABLE;
`endif
      end
`ifdef BOARD_SEQ_STABLE_DETECT_EN
      ST_STABLE: begin
        if (!run) state_nx = ST_IDLE;
        else if (wr_en || clear) state_nx = ST_RUN;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      board     <= '0;
      gen_count <= '0;
      gen_tick  <= 1'b0;
      pending   <= 1'b0;
      settle    <= SETTLE_LOAD;
    end else begin
      state    <= state_nx;
      gen_tick <= commit;

      if (settle != '0) settle <= settle - SW'(1);

      if (clear) begin
        board     <= '0;
        gen_count <= '0;
        settle    <= SETTLE_LOAD;
      end else if (wr_ok) begin
        board[wr_addr] <= wr_data;
        settle         <= SETTLE_LOAD;
      end else if (commit) begin
        board     <= board_next;
        gen_count <= gen_count + GEN_W'(1);
        settle    <= SETTLE_LOAD;
      end

      if (clear || leave_run) pending <= 1'b0;
      else if (set_pending)   pending <= 1'b1;
      else if (commit)        pending <= 1'b0;
    end
  end
endmodule

`default_nettype wire
